// File: rtl/des_decrypt_controller.sv
// des_decrypt_controller: iterative DES decrypt engine (IP, 16 rounds at one per clock, FP) with start/busy/ready handshake; ports clk, rst, start, desIn, keyIn -> busy, ready, desOut
module des_decrypt_controller #(
  parameter bit MODE_DECRYPT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] desIn,
  input  logic [63:0] keyIn,
  output logic        busy,
  output logic        ready,
  output logic [63:0] desOut
);
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
  localparam logic [6:0] IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
    62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8, 57,49,41,33,25,17,9,1,
    59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam logic [6:0] FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
    38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29, 36,4,44,12,52,20,60,28,
    35,3,43,11,51,19,59,27, 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam logic [6:0] E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13,
    12,13,14,15,16,17, 16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam logic [6:0] P_T [32] = '{16,7,20,21, 29,12,28,17, 1,15,23,26, 5,18,31,10,
    2,8,24,14, 32,27,3,9, 19,13,30,6, 22,11,4,25};
  localparam logic [6:0] PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
    10,2,59,51,43,35,27, 19,11,3,60,52,44,36, 63,55,47,39,31,23,15,
    7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam logic [6:0] PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8,
    16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam logic [3:0] SBOX [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};
  function automatic logic [63:0] ip(input logic [63:0] x);
    logic [63:0] y;
    for (int k = 0; k < 64; k++) y[6'(63 - k)] = x[6'(7'd64 - IP_T[k])];
    return y;
  endfunction
  function automatic logic [63:0] fp(input logic [63:0] x);
    logic [63:0] y;
    for (int k = 0; k < 64; k++) y[6'(63 - k)] = x[6'(7'd64 - FP_T[k])];
    return y;
  endfunction
  function automatic logic [55:0] pc1(input logic [63:0] x);
    logic [55:0] y;
    for (int k = 0; k < 56; k++) y[6'(55 - k)] = x[6'(7'd64 - PC1_T[k])];
    return y;
  endfunction
  function automatic logic [47:0] pc2(input logic [55:0] x);
    logic [47:0] y;
    for (int k = 0; k < 48; k++) y[6'(47 - k)] = x[6'(7'd56 - PC2_T[k])];
    return y;
  endfunction
  function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] key);
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] y;
    logic [5:0] b;
    for (int k = 0; k < 48; k++) x[6'(47 - k)] = r[5'(7'd32 - E_T[k])];
    x = x ^ key;
    for (int k = 0; k < 8; k++) begin
      b = x[6'(47 - 6 * k) -: 6];
      // row is the outer bit pair, column the middle four
      s[5'(31 - 4 * k) -: 4] = SBOX[3'(k)][{b[5], b[0], b[4:1]}];
    end
    for (int k = 0; k < 32; k++) y[5'(31 - k)] = s[5'(7'd32 - P_T[k])];
    return y;
  endfunction
  function automatic logic [27:0] rot(input logic [27:0] x, input logic [1:0] a);
    if (MODE_DECRYPT)
      return a == 2'd2 ? {x[1:0], x[27:2]} : a == 2'd1 ? {x[0], x[27:1]} : x;
    return a == 2'd2 ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction
  state_t state, state_n;
  logic [31:0] l, r, r_n;
  logic [27:0] c, d, c_n, d_n;
  logic [4:0] rnd;
  logic [1:0] amt;
  logic accept, last;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      {l, r, c, d, rnd, desOut} <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        {l, r} <= ip(desIn);
        {c, d} <= pc1(keyIn);
        rnd <= 5'd1;
      end else if (state == ROUND) begin
        l <= r;
        r <= r_n;
        c <= c_n;
        d <= d_n;
        rnd <= last ? rnd : rnd + 5'd1;
        if (last) desOut <= fp({r_n, r});
      end
    end
  end
  always_comb begin
    accept = start && state != ROUND;
    last = rnd == 5'd16;
    state_n = accept ? ROUND : (state == ROUND && last) ? DONE : state;
  end
  always_comb begin
    // round 1 of decryption uses PC1 unrotated (K16); shift-by-one rounds sit at 2, 9, 16 either way
    amt = (MODE_DECRYPT && rnd == 5'd1) ? 2'd0 :
          (rnd == 5'd1 || rnd == 5'd2 || rnd == 5'd9 || rnd == 5'd16) ? 2'd1 : 2'd2;
    c_n = rot(c, amt);
    d_n = rot(d, amt);
    r_n = l ^ feistel(r, pc2({c_n, d_n}));
    busy = state == ROUND;
    ready = state == DONE;
  end
endmodule

// File: tb/tb_des_decrypt_controller.sv
// tb_des_decrypt_controller: table vectors, handshake corner cases and encrypt/decrypt loopback with a scoreboard queue
module tb_des_decrypt_controller;
  typedef struct {
    logic [63:0] key;
    logic [63:0] din;
    logic [63:0] exp;
  } vec_t;
  logic clk = 0, rst = 1, start = 0, e_start = 0;
  logic [63:0] desIn = '0, keyIn = '0, e_in = '0, e_key = '0;
  logic busy, ready, e_busy, e_ready;
  logic [63:0] desOut, e_out;
  int checks = 0, failures = 0;
  logic [63:0] exp_q [$];
  vec_t vecs [4];
  always #5 clk = ~clk;
  des_decrypt_controller dut (.clk(clk), .rst(rst), .start(start), .desIn(desIn), .keyIn(keyIn),
    .busy(busy), .ready(ready), .desOut(desOut));
  des_decrypt_controller #(.MODE_DECRYPT(1'b0)) enc (.clk(clk), .rst(rst), .start(e_start),
    .desIn(e_in), .keyIn(e_key), .busy(e_busy), .ready(e_ready), .desOut(e_out));
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", tag, act, exp);
    end
  endtask
  task automatic launch(input logic [63:0] key, input logic [63:0] din, input logic [63:0] exp);
    @(negedge clk);
    keyIn = key;
    desIn = din;
    start = 1;
    exp_q.push_back(exp);
    @(negedge clk);
    start = 0;
    check("busy_after_start", 64'(busy), 64'd1);
    check("ready_after_start", 64'(ready), 64'd0);
  endtask
  task automatic finish_block(input string tag, input int lat_exp);
    int n;
    logic [63:0] e;
    n = 0;
    while (!ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(lat_exp));
    e = exp_q.size() > 0 ? exp_q.pop_front() : 64'hx;
    check({tag, "_desOut"}, desOut, e);
  endtask
  initial begin
    logic [63:0] k, pt, held;
    int n;
    vecs[0] = '{64'h133457799BBCDFF1, 64'h85E813540F0AB405, 64'h0123456789ABCDEF};
    vecs[1] = '{64'h0E329232EA6D0D73, 64'h0000000000000000, 64'h8787878787878787};
    vecs[2] = '{64'h0000000000000000, 64'h8CA64DE9C1B123A7, 64'h0000000000000000};
    vecs[3] = vecs[0];
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_ready", 64'(ready), 64'd0);
    check("reset_desOut", desOut, 64'd0);
    rst = 0;
    @(negedge clk);
    check("idle_ready", 64'(ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      launch(vecs[i].key, vecs[i].din, vecs[i].exp);
      finish_block($sformatf("vec%0d", i), 16);
      check($sformatf("vec%0d_busy_done", i), 64'(busy), 64'd0);
    end
    @(negedge clk);
    keyIn = vecs[0].key;
    desIn = vecs[0].din;
    start = 1;
    exp_q.push_back(vecs[0].exp);
    @(negedge clk);
    desIn = 64'hDEADBEEFCAFEF00D;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    finish_block("start_while_busy", 11);
    held = desOut;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      n += (busy || !ready || desOut !== held) ? 1 : 0;
    end
    check("done_held", 64'(n), 64'd0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    launch(vecs[0].key, vecs[0].din, vecs[0].exp);
    repeat (7) @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_ready", 64'(ready), 64'd0);
    check("midrst_desOut", desOut, 64'd0);
    rst = 0;
    exp_q.delete();
    launch(vecs[0].key, vecs[0].din, vecs[0].exp);
    finish_block("after_rst", 16);
    @(negedge clk);
    e_key = vecs[0].key;
    e_in = vecs[0].exp;
    e_start = 1;
    @(negedge clk);
    e_start = 0;
    n = 0;
    while (!e_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("enc_latency", 64'(n), 64'd16);
    check("enc_vec1", e_out, vecs[0].din);
    for (int i = 0; i < 200; i++) begin
      k = {$urandom, $urandom};
      pt = {$urandom, $urandom};
      @(negedge clk);
      e_key = k;
      e_in = pt;
      e_start = 1;
      @(negedge clk);
      e_start = 0;
      n = 0;
      while (!e_ready && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("loop_enc_latency", 64'(n), 64'd16);
      launch(k, e_out, pt);
      finish_block("loopback", 16);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
